debug_dma_ctrl: RTL and testbench

Per-thread sequencer for the on-chip debug DMA engine. Holds one DMA context (target virtual address, buffer pointer, word count, command) per hardware thread, loads it from the host command interface, presents it with the injected LD/ST instruction at instruction fetch, and advances or retires it from the commit-stage acknowledgement. Sits between the host-side command interface, the DMA read buffer and the integer pipeline's ifetch and xc/com stages.

---
 rtl/debug_dma_ctrl_pkg.sv | 91 +++++++++
 rtl/debug_dma_ctrl_if.sv | 30 +++
 rtl/debug_dma_ctrl_ctx_ram.sv | 69 ++++++
 rtl/debug_dma_ctrl.sv | 157 +++++++++++++++
 tb/tb_debug_dma_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_dma_ctrl_pkg.sv
// debug_dma_ctrl_pkg
// Shared parameters, enums and structs for the per-thread debug DMA
// sequencer, plus the even-parity helper used on host register writes.
// Contents:
//   NTHREAD / NTHREADIDMSB / DMABUFMSB : table depth and field widths
//   debug_dma_cmdif_in_type  : host command write (tid, addr_reg, ctrl_reg, enables)
//   debug_dma_in_type        : commit feedback (tid, ack, done)
//   debug_dma_out_type       : injected instruction plus context snapshot
//   debug_dma_ctx_type       : one stored context (addr, buf_addr, count, cmd)
//   debug_dma_done_type      : retire notification (valid, tid)
package debug_dma_ctrl_pkg;

  localparam int NTHREAD      = 64;
  localparam int NTHREADIDMSB = 5;
  localparam int DMABUFMSB    = 9;

  localparam logic [DMABUFMSB:0] DMA_BUF_ONE = {{DMABUFMSB{1'b0}}, 1'b1};

  typedef logic [NTHREADIDMSB:0] thread_id_type;

  typedef enum logic {
    dma_NOP = 1'b0,
    dma_OP  = 1'b1
  } debug_dma_cmd_type;

  typedef struct packed {
    logic        parity;
    logic [29:0] addr;
  } debug_dma_addr_reg_type;

  typedef struct packed {
    logic              parity;
    debug_dma_cmd_type cmd;
    logic [DMABUFMSB:0] count;
    logic [DMABUFMSB:0] buf_addr;
  } debug_dma_ctrl_reg_type;

  typedef struct packed {
    thread_id_type          tid;
    debug_dma_addr_reg_type addr_reg;
    logic                   addr_we;
    debug_dma_ctrl_reg_type ctrl_reg;
    logic                   ctrl_we;
  } debug_dma_cmdif_in_type;

  typedef struct packed {
    thread_id_type tid;
    logic          ack;
    logic          done;
  } debug_dma_in_type;

  typedef struct packed {
    logic [29:0]        addr;
    logic [DMABUFMSB:0] buf_addr;
    logic [DMABUFMSB:0] count;
    debug_dma_cmd_type  cmd;
  } debug_dma_ctx_type;

  typedef struct packed {
    logic          valid;
    thread_id_type tid;
  } debug_dma_done_type;

  // Context snapshot handed to the pipeline with the injected instruction.
  typedef struct packed {
    logic [29:0]        addr;
    logic [31:0]        data;
    logic [DMABUFMSB:0] count;
    logic [DMABUFMSB:0] buf_addr;
    debug_dma_cmd_type  cmd;
  } debug_dma_iu_state_type;

  typedef struct packed {
    logic [31:0]            inst;
    debug_dma_iu_state_type state;
  } debug_dma_out_type;

  localparam debug_dma_iu_state_type debug_dma_iu_state_none = '{
    addr:     30'd0,
    data:     32'd0,
    count:    {(DMABUFMSB+1){1'b0}},
    buf_addr: {(DMABUFMSB+1){1'b0}},
    cmd:      dma_NOP
  };

  // True when the vector (data bits plus its parity bit) has an even number of ones.
  function automatic logic parity_ok(input logic [63:0] bits);
    return ~(^bits);
  endfunction

endpackage

// File: rtl/debug_dma_ctrl_if.sv
// debug_dma_ctrl_if
// Bundles the host command, fetch, read-buffer, commit and status signals of
// the debug DMA sequencer.
//   master : host / pipeline side (drives cmd_in, if_valid, if_tid, rbuf_inst, com_in)
//   slave  : debug_dma_ctrl (drives rbuf_addr, dma_out, busy, done_valid, done_tid)
interface debug_dma_ctrl_if;
  import debug_dma_ctrl_pkg::*;

  debug_dma_cmdif_in_type cmd_in;
  logic                   if_valid;
  thread_id_type          if_tid;
  logic [DMABUFMSB:0]     rbuf_addr;
  logic [31:0]            rbuf_inst;
  debug_dma_out_type      dma_out;
  debug_dma_in_type       com_in;
  logic [NTHREAD-1:0]     busy;
  logic                   done_valid;
  thread_id_type          done_tid;

  modport master (
    output cmd_in, if_valid, if_tid, rbuf_inst, com_in,
    input  rbuf_addr, dma_out, busy, done_valid, done_tid
  );

  modport slave (
    input  cmd_in, if_valid, if_tid, rbuf_inst, com_in,
    output rbuf_addr, dma_out, busy, done_valid, done_tid
  );

endinterface

// File: rtl/debug_dma_ctrl_ctx_ram.sv
// debug_dma_ctrl_ctx_ram
// NTHREAD-deep context table. Two asynchronous read ports (fetch and commit
// thread), a commit update port and a field-granular host write port. Host
// fields are written after the commit update so they take precedence.
// Reset clears every entry so all contexts come back as zero / dma_NOP.
// Ports:
//   gclk, rst                 clock, async active-high reset
//   host_*                    host write (tid, addr/ctrl enables and fields)
//   com_we, com_tid, com_ctx  commit-side full context update
//   rd_a_tid / rd_a_ctx       fetch read port
//   rd_b_tid / rd_b_ctx       commit read port
//   cmd_vec                   bit t = context t holds dma_OP
module debug_dma_ctrl_ctx_ram
  import debug_dma_ctrl_pkg::*;
(
  input  logic               gclk,
  input  logic               rst,
  input  thread_id_type      host_tid,
  input  logic               host_addr_we,
  input  logic [29:0]        host_addr,
  input  logic               host_ctrl_we,
  input  logic [DMABUFMSB:0] host_buf_addr,
  input  logic [DMABUFMSB:0] host_count,
  input  debug_dma_cmd_type  host_cmd,
  input  logic               com_we,
  input  thread_id_type      com_tid,
  input  debug_dma_ctx_type  com_ctx,
  input  thread_id_type      rd_a_tid,
  output debug_dma_ctx_type  rd_a_ctx,
  input  thread_id_type      rd_b_tid,
  output debug_dma_ctx_type  rd_b_ctx,
  output logic [NTHREAD-1:0] cmd_vec
);

  debug_dma_ctx_type mem [NTHREAD];

  assign rd_a_ctx = mem[rd_a_tid];
  assign rd_b_ctx = mem[rd_b_tid];

  // Context storage: commit update first, host fields override on the same entry.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTHREAD; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (com_we) begin
        mem[com_tid] <= com_ctx;
      end
      if (host_addr_we) begin
        mem[host_tid].addr <= host_addr;
      end
      if (host_ctrl_we) begin
        mem[host_tid].buf_addr <= host_buf_addr;
        mem[host_tid].count    <= host_count;
        mem[host_tid].cmd      <= host_cmd;
      end
    end
  end

  // Per-thread busy flags straight from the stored command.
  always_comb begin
    cmd_vec = '0;
    for (int i = 0; i < NTHREAD; i++) begin
      cmd_vec[i] = (mem[i].cmd == dma_OP);
    end
  end

endmodule

// File: rtl/debug_dma_ctrl.sv
// debug_dma_ctrl
// Per-thread debug DMA sequencer. Loads contexts from host writes, presents
// the read-buffer instruction plus a context snapshot one cycle after a fetch,
// and advances or retires the context on commit acknowledgements.
// Optional feature macro: DEBUG_DMA_PARITY_EN -- even parity check on host
// addr_reg / ctrl_reg writes; a failing write is discarded and the sticky
// parity_err output is set (cleared only by rst).
// Ports:
//   gclk        pipeline clock
//   rst         async active-high reset
//   bus         debug_dma_ctrl_if.slave (cmd_in, if_valid, if_tid, rbuf_addr,
//               rbuf_inst, dma_out, com_in, busy, done_valid, done_tid)
//   parity_err  sticky parity error (only with DEBUG_DMA_PARITY_EN)
module debug_dma_ctrl
  import debug_dma_ctrl_pkg::*;
(
  input  logic           gclk,
  input  logic           rst,
  debug_dma_ctrl_if.slave bus
`ifdef DEBUG_DMA_PARITY_EN
  ,
  output logic           parity_err
`endif
);

  logic                   addr_ok;
  logic                   ctrl_ok;
  logic                   addr_wr;
  logic                   ctrl_wr;
  logic                   host_hit;
  debug_dma_cmd_type      host_cmd;
  debug_dma_ctx_type      ctx_f;
  debug_dma_ctx_type      ctx_c;
  logic                   com_we;
  debug_dma_ctx_type      com_ctx;
  logic                   retire;
  logic                   snap_op;
  debug_dma_iu_state_type snap_state;
  debug_dma_done_type     done;
  logic [NTHREAD-1:0]     cmd_vec;

`ifdef DEBUG_DMA_PARITY_EN
  assign addr_ok = parity_ok({33'd0, bus.cmd_in.addr_reg});
  assign ctrl_ok = parity_ok({42'd0, bus.cmd_in.ctrl_reg});
`else
  assign addr_ok = 1'b1;
  assign ctrl_ok = 1'b1;
`endif

  assign addr_wr  = bus.cmd_in.addr_we & addr_ok;
  assign ctrl_wr  = bus.cmd_in.ctrl_we & ctrl_ok;
  // Any accepted host write to the committing thread cancels that commit.
  assign host_hit = (addr_wr | ctrl_wr) && (bus.cmd_in.tid == bus.com_in.tid);

  // A transfer of zero words is loaded as nothing-to-do.
  always_comb begin
    host_cmd = dma_NOP;
    if ((bus.cmd_in.ctrl_reg.cmd == dma_OP) && (bus.cmd_in.ctrl_reg.count != '0)) begin
      host_cmd = dma_OP;
    end else begin
      host_cmd = dma_NOP;
    end
  end

  debug_dma_ctrl_ctx_ram u_ctx_ram (
    .gclk          (gclk),
    .rst           (rst),
    .host_tid      (bus.cmd_in.tid),
    .host_addr_we  (addr_wr),
    .host_addr     (bus.cmd_in.addr_reg.addr),
    .host_ctrl_we  (ctrl_wr),
    .host_buf_addr (bus.cmd_in.ctrl_reg.buf_addr),
    .host_count    (bus.cmd_in.ctrl_reg.count),
    .host_cmd      (host_cmd),
    .com_we        (com_we),
    .com_tid       (bus.com_in.tid),
    .com_ctx       (com_ctx),
    .rd_a_tid      (bus.if_tid),
    .rd_a_ctx      (ctx_f),
    .rd_b_tid      (bus.com_in.tid),
    .rd_b_ctx      (ctx_c),
    .cmd_vec       (cmd_vec)
  );

  // Commit-side next context: advance on ack, stop on abort, retire on last word.
  always_comb begin
    com_we  = 1'b0;
    com_ctx = ctx_c;
    retire  = 1'b0;
    if ((ctx_c.cmd == dma_OP) && !host_hit) begin
      if (bus.com_in.ack) begin
        com_we           = 1'b1;
        com_ctx.addr     = ctx_c.addr + 30'd1;
        com_ctx.buf_addr = ctx_c.buf_addr + DMA_BUF_ONE;
        com_ctx.count    = ctx_c.count - DMA_BUF_ONE;
        if (ctx_c.count == DMA_BUF_ONE) begin
          com_ctx.cmd = dma_NOP;
          retire      = 1'b1;
        end else begin
          com_ctx.cmd = dma_OP;
        end
      end else if (bus.com_in.done) begin
        com_we      = 1'b1;
        com_ctx.cmd = dma_NOP;
        retire      = 1'b1;
      end else begin
        com_we = 1'b0;
      end
    end else begin
      com_we = 1'b0;
    end
  end

  // Fetch snapshot and retire pulse registers.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      snap_op    <= 1'b0;
      snap_state <= debug_dma_iu_state_none;
      done       <= '0;
    end else begin
      if (bus.if_valid && (ctx_f.cmd == dma_OP)) begin
        snap_op    <= 1'b1;
        snap_state <= '{addr:     ctx_f.addr,
                        data:     32'd0,
                        count:    ctx_f.count,
                        buf_addr: ctx_f.buf_addr,
                        cmd:      dma_OP};
      end else begin
        snap_op    <= 1'b0;
        snap_state <= debug_dma_iu_state_none;
      end
      done.valid <= retire;
      done.tid   <= retire ? bus.com_in.tid : '0;
    end
  end

`ifdef DEBUG_DMA_PARITY_EN
  // Sticky flag for any host write rejected on parity.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if ((bus.cmd_in.addr_we && !addr_ok) || (bus.cmd_in.ctrl_we && !ctrl_ok)) begin
      parity_err <= 1'b1;
    end else begin
      parity_err <= parity_err;
    end
  end
`endif

  // The read buffer returns data one cycle after rbuf_addr, aligned with the snapshot.
  assign bus.rbuf_addr  = ctx_f.buf_addr;
  assign bus.dma_out    = '{inst: (snap_op ? bus.rbuf_inst : 32'd0), state: snap_state};
  assign bus.busy       = cmd_vec;
  assign bus.done_valid = done.valid;
  assign bus.done_tid   = done.tid;

endmodule

// File: tb/tb_debug_dma_ctrl.sv
module tb_debug_dma_ctrl;
  import debug_dma_ctrl_pkg::*;

  logic gclk = 1'b0;
  logic rst  = 1'b1;
  always #5 gclk = ~gclk;

  debug_dma_ctrl_if bus ();

`ifdef DEBUG_DMA_PARITY_EN
  logic parity_err;
  debug_dma_ctrl dut (.gclk(gclk), .rst(rst), .bus(bus), .parity_err(parity_err));
`else
  debug_dma_ctrl dut (.gclk(gclk), .rst(rst), .bus(bus));
`endif

  // Synchronous read buffer model: one-cycle read latency.
  logic [31:0] bufmem [1024];
  always @(posedge gclk) bus.rbuf_inst <= bufmem[bus.rbuf_addr];

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          op;
    int unsigned addr;
    int          cnt;
    int          bufa;
    logic [31:0] inst;
    bit          dv;
    int          dt;
  } exp_t;

  int unsigned m_addr [64];
  int          m_buf  [64];
  int          m_cnt  [64];
  bit          m_op   [64];

  exp_t        exp_cur = '{default: 0};
  exp_t        exp_nxt = '{default: 0};
  int          exp_rbuf = 0;
  logic [63:0] exp_busy = '0;

  int n_vec = 0;
  int n_err = 0;

  // literal expectations: pushed by stimulus, consumed by the compare process
  string       lit_nm  [$];
  int          lit_sel [$];
  logic [95:0] lit_val [$];
  int          lit_rd = 0;

  // staged stimulus for the next cycle
  debug_dma_cmdif_in_type st_cmd;
  debug_dma_in_type       st_com;
  bit                     st_ifv;
  thread_id_type          st_ift;
  bit                     st_bad;

  function automatic debug_dma_iu_state_type mk_state(input exp_t e);
    debug_dma_iu_state_type s;
    int unsigned a;
    int c;
    int b;
    s = debug_dma_iu_state_none;
    a = e.addr;
    c = e.cnt;
    b = e.bufa;
    if (e.op) begin
      s.addr = a[29:0];
      s.count = c[9:0];
      s.buf_addr = b[9:0];
      s.cmd = dma_OP;
    end
    return s;
  endfunction

  function automatic logic [95:0] actual_of(input int sel);
    case (sel)
      0: return 96'(bus.dma_out.state.addr);
      1: return 96'(bus.dma_out.state.count);
      2: return 96'(bus.dma_out.state.buf_addr);
      3: return 96'(bus.dma_out.inst);
      4: return 96'(bus.busy[3]);
      5: return 96'(bus.rbuf_addr);
      6: return 96'(bus.done_valid);
      7: return 96'(bus.done_tid);
      8: return 96'(bus.busy);
      9: return 96'(bus.dma_out.state.cmd);
`ifdef DEBUG_DMA_PARITY_EN
      10: return 96'(parity_err);
`endif
      default: return 96'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model outputs every cycle plus any pending literals.
  always @(negedge gclk) begin
    chk("rbuf_addr", 96'(bus.rbuf_addr), 96'(exp_rbuf));
    chk("dma_state", 96'(bus.dma_out.state), 96'(mk_state(exp_cur)));
    chk("dma_inst", 96'(bus.dma_out.inst), 96'(exp_cur.op ? exp_cur.inst : 32'd0));
    chk("busy", 96'(bus.busy), 96'(exp_busy));
    chk("done_valid", 96'(bus.done_valid), 96'(exp_cur.dv));
    chk("done_tid", 96'(bus.done_tid), 96'(exp_cur.dt));
    while (lit_rd < lit_nm.size()) begin
      chk(lit_nm[lit_rd], actual_of(lit_sel[lit_rd]), lit_val[lit_rd]);
      lit_rd++;
    end
  end

  task automatic lit(input string nm, input int sel, input logic [95:0] v);
    lit_nm.push_back(nm);
    lit_sel.push_back(sel);
    lit_val.push_back(v);
  endtask

  task automatic idle_stage();
    st_cmd = '0;
    st_com = '0;
    st_ifv = 1'b0;
    st_ift = '0;
    st_bad = 1'b0;
  endtask

  task automatic drive_idle();
    bus.cmd_in   = '0;
    bus.com_in   = '0;
    bus.if_valid = 1'b0;
    bus.if_tid   = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_addr[i] = 0;
      m_buf[i]  = 0;
      m_cnt[i]  = 0;
      m_op[i]   = 0;
    end
    exp_cur  = '{default: 0};
    exp_nxt  = '{default: 0};
    exp_rbuf = 0;
    exp_busy = '0;
  endtask

  // One clock: apply staged inputs just after the edge, predict the next edge.
  task automatic tick();
    exp_t nx;
    int   t;
    int   ct;
    bit   aw;
    bit   cw;
    @(posedge gclk);
    #1;
    exp_cur = exp_nxt;
    st_cmd.addr_reg.parity = ^st_cmd.addr_reg.addr;
    st_cmd.ctrl_reg.parity = ^{st_cmd.ctrl_reg.cmd, st_cmd.ctrl_reg.count, st_cmd.ctrl_reg.buf_addr};
    aw = st_cmd.addr_we;
    cw = st_cmd.ctrl_we;
`ifdef DEBUG_DMA_PARITY_EN
    if (st_bad) begin
      st_cmd.ctrl_reg.parity = ~st_cmd.ctrl_reg.parity;
      cw = 1'b0;
    end
`endif
    bus.cmd_in   = st_cmd;
    bus.com_in   = st_com;
    bus.if_valid = st_ifv;
    bus.if_tid   = st_ift;

    for (int i = 0; i < 64; i++) exp_busy[i] = m_op[i];
    exp_rbuf = m_buf[st_ift];

    nx = '{default: 0};
    t = int'(st_ift);
    if (st_ifv && m_op[t]) begin
      nx.op   = 1;
      nx.addr = m_addr[t];
      nx.cnt  = m_cnt[t];
      nx.bufa = m_buf[t];
      nx.inst = bufmem[m_buf[t]];
    end

    ct = int'(st_com.tid);
    if (!((aw || cw) && (st_cmd.tid == st_com.tid)) && m_op[ct]) begin
      if (st_com.ack) begin
        m_addr[ct] = (m_addr[ct] + 1) & 32'h3FFF_FFFF;
        m_buf[ct]  = (m_buf[ct] + 1) % 1024;
        m_cnt[ct]  = m_cnt[ct] - 1;
        if (m_cnt[ct] == 0) begin
          m_op[ct] = 0;
          nx.dv = 1;
          nx.dt = ct;
        end
      end else if (st_com.done) begin
        m_op[ct] = 0;
        nx.dv = 1;
        nx.dt = ct;
      end
    end

    t = int'(st_cmd.tid);
    if (aw) m_addr[t] = st_cmd.addr_reg.addr;
    if (cw) begin
      m_buf[t] = st_cmd.ctrl_reg.buf_addr;
      m_cnt[t] = st_cmd.ctrl_reg.count;
      m_op[t]  = (st_cmd.ctrl_reg.cmd == dma_OP) && (st_cmd.ctrl_reg.count != 10'd0);
    end
    exp_nxt = nx;
    idle_stage();
  endtask

  task automatic host_addr(input int t, input int unsigned a);
    st_cmd.tid = 6'(t);
    st_cmd.addr_we = 1'b1;
    st_cmd.addr_reg.addr = 30'(a);
  endtask

  task automatic host_ctrl(input int t, input int b, input int c, input bit op);
    st_cmd.tid = 6'(t);
    st_cmd.ctrl_we = 1'b1;
    st_cmd.ctrl_reg.buf_addr = 10'(b);
    st_cmd.ctrl_reg.count = 10'(c);
    st_cmd.ctrl_reg.cmd = op ? dma_OP : dma_NOP;
  endtask

  task automatic fetch(input int t);
    st_ifv = 1'b1;
    st_ift = 6'(t);
  endtask

  task automatic commit(input int t, input bit a, input bit d);
    st_com.tid = 6'(t);
    st_com.ack = a;
    st_com.done = d;
  endtask

  // Asynchronous reset between edges, checked before the next edge.
  task automatic do_reset();
    @(posedge gclk);
    #1;
    drive_idle();
    #2;
    rst = 1'b1;
    model_reset();
    lit("rst_busy", 8, 96'h0);
    lit("rst_inst", 3, 96'h0);
    lit("rst_state_cmd", 9, 96'h0);
    lit("rst_done_valid", 6, 96'h0);
    @(posedge gclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    drive_idle();
    idle_stage();
    model_reset();
    for (int i = 0; i < 1024; i++) bufmem[i] = $urandom;
    bufmem[5] = 32'hCAFE_0005;
    repeat (2) @(posedge gclk);
    #1;
    rst = 1'b0;

    // tid 3: addr 0x100, buf 5, count 2
    host_addr(3, 32'h100); host_ctrl(3, 5, 2, 1'b1); tick();
    fetch(3); tick();
    lit("t3_rbuf_addr", 5, 96'd5);
    lit("t3_busy", 4, 96'd1);
    commit(3, 1'b1, 1'b0); tick();
    lit("t3_state_addr", 0, 96'h100);
    lit("t3_state_count", 1, 96'd2);
    lit("t3_state_buf", 2, 96'd5);
    lit("t3_inst", 3, 96'hCAFE_0005);
    commit(3, 1'b1, 1'b0); tick();
    fetch(3); tick();
    lit("t3_done_valid", 6, 96'd1);
    lit("t3_done_tid", 7, 96'd3);
    lit("t3_busy_clear", 4, 96'd0);
    lit("t3_buf_after", 5, 96'd7);
    tick();
    lit("t3_nop_inst", 3, 96'd0);
    lit("t3_pulse_end", 6, 96'd0);
    host_ctrl(3, 9, 1, 1'b1); tick();
    fetch(3); tick();
    tick();
    lit("t3_addr_after", 0, 96'h102);

    // wrap of buf_addr and addr on tid 4
    host_addr(4, 32'h3FFF_FFFF); host_ctrl(4, 1023, 2, 1'b1); tick();
    commit(4, 1'b1, 1'b0); tick();
    fetch(4); tick();
    lit("t4_rbuf_wrap", 5, 96'd0);
    tick();
    lit("t4_addr_wrap", 0, 96'd0);
    lit("t4_count", 1, 96'd1);

    // host write and ack to tid 7 in the same cycle
    host_addr(7, 32'h200); host_ctrl(7, 10, 3, 1'b1); tick();
    host_ctrl(7, 20, 5, 1'b1); commit(7, 1'b1, 1'b0); tick();
    fetch(7); tick();
    lit("t7_no_pulse", 6, 96'd0);
    tick();
    lit("t7_count", 1, 96'd5);
    lit("t7_buf", 2, 96'd20);
    lit("t7_addr", 0, 96'h200);

    // abort tid 2 mid-transfer
    host_addr(2, 32'h40); host_ctrl(2, 30, 4, 1'b1); tick();
    commit(2, 1'b0, 1'b1); tick();
    fetch(2); tick();
    lit("t2_abort_pulse", 6, 96'd1);
    lit("t2_abort_tid", 7, 96'd2);
    tick();
    lit("t2_nop_cmd", 9, 96'd0);
    lit("t2_nop_inst", 3, 96'd0);

    // reset while tids 0..3 are busy and tid 1 is being presented
    for (int t = 0; t < 4; t++) begin
      host_ctrl(t, 100 + t, 3, 1'b1); tick();
    end
    fetch(1); tick();
    do_reset();

`ifdef DEBUG_DMA_PARITY_EN
    host_ctrl(5, 3, 2, 1'b1); st_bad = 1'b1; tick();
    tick();
    lit("parity_err", 10, 96'd1);
`endif

    // randomized traffic concentrated on a few threads
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        st_cmd.tid = 6'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) begin
          st_cmd.addr_we = 1'b1;
          st_cmd.addr_reg.addr = ($urandom_range(0, 3) == 0) ?
                                 30'(32'h3FFF_FFFE + $urandom_range(0, 1)) : 30'($urandom);
        end
        if ($urandom_range(0, 1) == 1) begin
          st_cmd.ctrl_we = 1'b1;
          st_cmd.ctrl_reg.buf_addr = ($urandom_range(0, 2) == 0) ?
                                     10'(1020 + $urandom_range(0, 3)) : 10'($urandom);
          st_cmd.ctrl_reg.count = 10'($urandom_range(0, 4));
          st_cmd.ctrl_reg.cmd = ($urandom_range(0, 4) == 0) ? dma_NOP : dma_OP;
        end
      end
      st_ifv = ($urandom_range(0, 3) != 0);
      st_ift = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      begin
        int r;
        r = $urandom_range(0, 15);
        st_com.tid  = 6'($urandom_range(0, 7));
        st_com.ack  = (r < 8) || (r == 9);
        st_com.done = (r == 8) || (r == 9);
      end
      tick();
    end
    tick();
    tick();
    @(negedge gclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
